lector_destinos: RTL and testbench
==================================

# lector_destinos

Egress reader of the PCIe transaction block: drains the two destination FIFOs (D0, D1) that the ingress side fills via `push`/`data_in_principal`. Arbitrates round-robin between non-empty FIFOs, issues pops, and presents one registered word per cycle downstream. Honours downstream backpressure, checks that each word's destination bit matches its FIFO, and reports idle/active/error status with the block's usual state naming.

## Interface
- `BUS_WIDTH`, 6, word width; bit5 = VC, bit4 = destination, bits3:0 = data
- `CNT_WIDTH`, 5, width of per-destination word counters (saturating)
- `clk` in 1 — single clock, all state on rising edge
- `reset_L` in 1 — asynchronous, active-low reset
- `init` in 1 — synchronous re-initialisation request
- `fifo_empty_d0`, `fifo_empty_d1` in 1 each — head-empty flags of D0/D1 FIFOs
- `data_d0`, `data_d1` in BUS_WIDTH each — FIFO head word (first-word-fall-through, valid when not empty)
- `pausa_out` in 1 — downstream backpressure; 1 = no word may be popped this cycle
- `pop_d0`, `pop_d1` out 1 each — pop strobes, at most one high per cycle
- `data_out` out BUS_WIDTH — registered popped word
- `valid_out` out 1 — `data_out` carries a new word this cycle
- `cont_d0`, `cont_d1` out CNT_WIDTH each — words popped per destination since INIT
- `idle_out`, `active_out`, `error_out` out 1 each — state indicators

## Operation
- States: RESET, INIT, IDLE, ACTIVE, ERROR.
- `reset_L`=0: state RESET, all outputs 0, RR pointer = D1 (D0 served first).
- RESET -> INIT on first edge with `reset_L`=1.
- INIT: counters cleared, error cleared; stays while `init`=1; -> IDLE when `init`=0.
- `init`=1 in any state -> INIT next edge (overrides everything except reset).
- IDLE: `idle_out`=1, no pops; -> ACTIVE when either FIFO non-empty.
- ACTIVE: `active_out`=1; pop when `pausa_out`=0 and a FIFO is non-empty.
  - Both non-empty: pop the FIFO not served last; one non-empty: pop it; pointer updates on every pop.
  - -> IDLE when both FIFOs empty.
- Destination check: popped word from D0 with bit4=1, or from D1 with bit4=0 -> ERROR next edge; word is still output.
- ERROR: `error_out`=1, no pops, sticky until `init` or reset.
- Counters increment on each pop of their FIFO; saturate at 2^CNT_WIDTH-1, never wrap.

## Timing
- `pop_d0`/`pop_d1`: combinational from state, empties, `pausa_out`, RR pointer (same-cycle).
- Latency pop -> `data_out`/`valid_out`: 1 cycle (registered on the pop edge).
- No pop in a cycle -> `valid_out`=0 next cycle, `data_out` holds last value.
- `pausa_out`=1 blocks pop in that same cycle; resumption pops in the first cycle `pausa_out`=0.
- IDLE -> ACTIVE costs one cycle: first pop occurs the cycle after a FIFO becomes non-empty.
- Pop whose FIFO just went empty: no pop issued in cycle where flag is 1 (flag trusted as-is).
- `error_out`, `idle_out`, `active_out`, counters: registered, update edge after cause.
- Reset mid-stream: outputs to 0 immediately (async), in-flight `data_out` discarded.

## Structure
- Shared package: state encoding constants, field positions (VC bit5, DEST bit4, data 3:0), `BUS_WIDTH` default.
- One natural sub-module: `arbitro_rr` (2-way round-robin grant from two requests + pointer update).
- Counters and FSM stay in the top module.

## Test plan
- Reset: `reset_L`=0 mid-ACTIVE -> all outputs 0 same cycle; after release + `init` pulse, `idle_out`=1.
- D0 only, holding 6'b000011, 6'b001001 -> `pop_d0` two cycles, `data_out` 0x03 then 0x09, `cont_d0`=2, return to IDLE.
- D0 {0x03,0x09}, D1 {0x1B,0x1A} -> output order 0x03,0x1B,0x09,0x1A; `cont_d0`=`cont_d1`=2.
- `pausa_out`=1 for 3 cycles mid-stream -> no pops, `valid_out`=0 those cycles, order preserved after release.
- D0 head 6'b011011 (bit4=1) -> word output, `error_out`=1 next edge, pops stop; `init` pulse -> `error_out`=0, counters 0.
- 35 words into D1 -> `cont_d1` saturates at 31, no wrap.

Source files
------------

// File: rtl/lector_destinos_pkg.sv
// ---------------------------------------------------------------------------
// lector_destinos_pkg: state encoding and word field layout shared by the egress reader. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lector_destinos_pkg;

  localparam int BUS_WIDTH_DEF = 6;
  localparam int VC_BIT        = 5;
  localparam int DEST_BIT      = 4;
  localparam int DATA_MSB      = 3;
  localparam int DATA_LSB      = 0;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } estado_t;

  // D0 must carry DEST=0 and D1 must carry DEST=1.
  function automatic logic dest_mismatch(input logic from_d1, input logic dest_bit);
    return dest_bit != from_d1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lector_destinos_arbitro_rr.sv
// ---------------------------------------------------------------------------
// arbitro_rr: 2-way round-robin grant with a last-served pointer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arbitro_rr (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  // last_q = 1 means D1 was served last, so D0 wins the next tie.
  logic last_q;

  assign gnt0_o = en_i & req0_i & (~req1_i | last_q);
  assign gnt1_o = en_i & req1_i & (~req0_i | ~last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (clr_i) begin
      last_q <= 1'b1;
    end else if (gnt0_o) begin
      last_q <= 1'b0;
    end else if (gnt1_o) begin
      last_q <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lector_destinos.sv
// ---------------------------------------------------------------------------
// lector_destinos: egress reader draining the D0/D1 destination FIFOs. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lector_destinos
  import lector_destinos_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 init,
  input  logic                 fifo_empty_d0,
  input  logic                 fifo_empty_d1,
  input  logic [BUS_WIDTH-1:0] data_d0,
  input  logic [BUS_WIDTH-1:0] data_d1,
  input  logic                 pausa_out,
  output logic                 pop_d0,
  output logic                 pop_d1,
  output logic [BUS_WIDTH-1:0] data_out,
  output logic                 valid_out,
  output logic [CNT_WIDTH-1:0] cont_d0,
  output logic [CNT_WIDTH-1:0] cont_d1,
  output logic                 idle_out,
  output logic                 active_out,
  output logic                 error_out
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  estado_t                state_q, state_d;
  logic [BUS_WIDTH-1:0]   data_q;
  logic                   valid_q, idle_q, active_q, error_q;
  logic [CNT_WIDTH-1:0]   cont_d0_q, cont_d1_q;
  logic                   pop_any, mismatch, clr_ptr;
  logic [BUS_WIDTH-1:0]   word_sel;

  arbitro_rr u_arbitro (
    .clk    (clk),
    .rst_n  (reset_L),
    .clr_i  (clr_ptr),
    .en_i   ((state_q == ST_ACTIVE) & ~pausa_out),
    .req0_i (~fifo_empty_d0),
    .req1_i (~fifo_empty_d1),
    .gnt0_o (pop_d0),
    .gnt1_o (pop_d1)
  );

  assign pop_any  = pop_d0 | pop_d1;
  assign word_sel = pop_d1 ? data_d1 : data_d0;
  assign mismatch = (pop_d0 & dest_mismatch(1'b0, data_d0[DEST_BIT])) |
                    (pop_d1 & dest_mismatch(1'b1, data_d1[DEST_BIT]));
  // Re-initialisation also restarts arbitration with D0 first, as after reset.
  assign clr_ptr  = (state_d == ST_INIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   state_d = ST_IDLE;
      ST_IDLE:   if (!fifo_empty_d0 || !fifo_empty_d1) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (mismatch)                          state_d = ST_ERROR;
        else if (fifo_empty_d0 && fifo_empty_d1) state_d = ST_IDLE;
      end
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_INIT;
    endcase
    if (init) state_d = ST_INIT;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= ST_RESET;
      data_q    <= '0;
      valid_q   <= 1'b0;
      idle_q    <= 1'b0;
      active_q  <= 1'b0;
      error_q   <= 1'b0;
      cont_d0_q <= '0;
      cont_d1_q <= '0;
    end else begin
      state_q  <= state_d;
      idle_q   <= (state_d == ST_IDLE);
      active_q <= (state_d == ST_ACTIVE);
      error_q  <= (state_d == ST_ERROR);
      valid_q  <= pop_any;
      if (pop_any) data_q <= word_sel;
      if (state_d == ST_INIT) begin
        cont_d0_q <= '0;
        cont_d1_q <= '0;
      end else begin
        if (pop_d0 && cont_d0_q != CNT_MAX) cont_d0_q <= cont_d0_q + CNT_WIDTH'(1);
        if (pop_d1 && cont_d1_q != CNT_MAX) cont_d1_q <= cont_d1_q + CNT_WIDTH'(1);
      end
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign idle_out   = idle_q;
  assign active_out = active_q;
  assign error_out  = error_q;
  assign cont_d0    = cont_d0_q;
  assign cont_d1    = cont_d1_q;

endmodule

`default_nettype wire

// File: tb/tb_lector_destinos.sv
// ---------------------------------------------------------------------------
// tb_lector_destinos: directed vector table plus reset and saturation sequences. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lector_destinos;

  logic       clk;
  logic       reset_L;
  logic       init;
  logic       fifo_empty_d0, fifo_empty_d1;
  logic [5:0] data_d0, data_d1;
  logic       pausa_out;
  logic       pop_d0, pop_d1;
  logic [5:0] data_out;
  logic       valid_out;
  logic [4:0] cont_d0, cont_d1;
  logic       idle_out, active_out, error_out;

  int total = 0;
  int bad   = 0;

  lector_destinos #(.BUS_WIDTH(6), .CNT_WIDTH(5)) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .init          (init),
    .fifo_empty_d0 (fifo_empty_d0),
    .fifo_empty_d1 (fifo_empty_d1),
    .data_d0       (data_d0),
    .data_d1       (data_d1),
    .pausa_out     (pausa_out),
    .pop_d0        (pop_d0),
    .pop_d1        (pop_d1),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .cont_d0       (cont_d0),
    .cont_d1       (cont_d1),
    .idle_out      (idle_out),
    .active_out    (active_out),
    .error_out     (error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs for one cycle and what the DUT must show: pops in that cycle,
  // registered outputs after the following rising edge. xst = {idle,active,error}.
  typedef struct {
    logic       init;
    logic       e0;
    logic [5:0] d0;
    logic       e1;
    logic [5:0] d1;
    logic       pz;
    logic [1:0] xpop;
    logic       xv;
    logic [5:0] xd;
    logic [2:0] xst;
    logic [4:0] xc0;
    logic [4:0] xc1;
  } vec_t;

  function automatic vec_t mk(input logic i, input logic e0, input logic [5:0] d0,
                              input logic e1, input logic [5:0] d1, input logic pz,
                              input logic [1:0] xpop, input logic xv, input logic [5:0] xd,
                              input logic [2:0] xst, input logic [4:0] xc0, input logic [4:0] xc1);
    vec_t v;
    v.init = i;  v.e0 = e0; v.d0 = d0; v.e1 = e1; v.d1 = d1; v.pz = pz;
    v.xpop = xpop; v.xv = xv; v.xd = xd; v.xst = xst; v.xc0 = xc0; v.xc1 = xc1;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic apply_vec(input string name, input int idx, input vec_t v);
    @(negedge clk);
    init          = v.init;
    fifo_empty_d0 = v.e0;
    data_d0       = v.d0;
    fifo_empty_d1 = v.e1;
    data_d1       = v.d1;
    pausa_out     = v.pz;
    #2;
    chk({name, "_pop"}, idx, {30'd0, pop_d0, pop_d1}, {30'd0, v.xpop});
    @(posedge clk);
    #1;
    chk({name, "_out"}, idx,
        {12'd0, valid_out, data_out, idle_out, active_out, error_out, cont_d0, cont_d1},
        {12'd0, v.xv, v.xd, v.xst, v.xc0, v.xc1});
  endtask

  vec_t tbl [22];

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(1, 1, 6'h00, 1, 6'h00, 0, 2'b00, 0, 6'h00, 3'b000, 0, 0);
    tbl[1]  = mk(0, 1, 6'h00, 1, 6'h00, 0, 2'b00, 0, 6'h00, 3'b100, 0, 0);
    tbl[2]  = mk(0, 0, 6'h03, 1, 6'h00, 0, 2'b00, 0, 6'h00, 3'b010, 0, 0);
    tbl[3]  = mk(0, 0, 6'h03, 1, 6'h00, 0, 2'b10, 1, 6'h03, 3'b010, 1, 0);
    tbl[4]  = mk(0, 0, 6'h09, 1, 6'h00, 0, 2'b10, 1, 6'h09, 3'b010, 2, 0);
    tbl[5]  = mk(0, 1, 6'h00, 1, 6'h00, 0, 2'b00, 0, 6'h09, 3'b100, 2, 0);
    tbl[6]  = mk(1, 1, 6'h00, 1, 6'h00, 0, 2'b00, 0, 6'h09, 3'b000, 0, 0);
    tbl[7]  = mk(0, 1, 6'h00, 1, 6'h00, 0, 2'b00, 0, 6'h09, 3'b100, 0, 0);
    tbl[8]  = mk(0, 0, 6'h03, 0, 6'h1B, 0, 2'b00, 0, 6'h09, 3'b010, 0, 0);
    tbl[9]  = mk(0, 0, 6'h03, 0, 6'h1B, 0, 2'b10, 1, 6'h03, 3'b010, 1, 0);
    tbl[10] = mk(0, 0, 6'h09, 0, 6'h1B, 0, 2'b01, 1, 6'h1B, 3'b010, 1, 1);
    tbl[11] = mk(0, 0, 6'h09, 0, 6'h1A, 0, 2'b10, 1, 6'h09, 3'b010, 2, 1);
    tbl[12] = mk(0, 1, 6'h00, 0, 6'h1A, 1, 2'b00, 0, 6'h09, 3'b010, 2, 1);
    tbl[13] = mk(0, 1, 6'h00, 0, 6'h1A, 1, 2'b00, 0, 6'h09, 3'b010, 2, 1);
    tbl[14] = mk(0, 1, 6'h00, 0, 6'h1A, 1, 2'b00, 0, 6'h09, 3'b010, 2, 1);
    tbl[15] = mk(0, 1, 6'h00, 0, 6'h1A, 0, 2'b01, 1, 6'h1A, 3'b010, 2, 2);
    tbl[16] = mk(0, 1, 6'h00, 1, 6'h00, 0, 2'b00, 0, 6'h1A, 3'b100, 2, 2);
    tbl[17] = mk(0, 0, 6'h1B, 1, 6'h00, 0, 2'b00, 0, 6'h1A, 3'b010, 2, 2);
    tbl[18] = mk(0, 0, 6'h1B, 1, 6'h00, 0, 2'b10, 1, 6'h1B, 3'b001, 3, 2);
    tbl[19] = mk(0, 0, 6'h1B, 1, 6'h00, 0, 2'b00, 0, 6'h1B, 3'b001, 3, 2);
    tbl[20] = mk(1, 0, 6'h1B, 1, 6'h00, 0, 2'b00, 0, 6'h1B, 3'b000, 0, 0);
    tbl[21] = mk(0, 1, 6'h00, 1, 6'h00, 0, 2'b00, 0, 6'h1B, 3'b100, 0, 0);

    reset_L = 1'b0; init = 1'b0; pausa_out = 1'b0;
    fifo_empty_d0 = 1'b1; fifo_empty_d1 = 1'b1; data_d0 = '0; data_d1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 0,
        {10'd0, pop_d0, pop_d1, valid_out, data_out, idle_out, active_out, error_out, cont_d0, cont_d1},
        32'd0);
    reset_L = 1'b1;

    for (int i = 0; i < 22; i++) apply_vec("tbl", i, tbl[i]);

    // Asynchronous reset while a pop is being requested.
    apply_vec("rst_seq", 0, mk(0, 1, 6'h00, 0, 6'h11, 0, 2'b00, 0, 6'h1B, 3'b010, 0, 0));
    apply_vec("rst_seq", 1, mk(0, 1, 6'h00, 0, 6'h11, 0, 2'b01, 1, 6'h11, 3'b010, 0, 1));
    @(negedge clk);
    #2;
    reset_L = 1'b0;
    #1;
    chk("rst_async", 0,
        {10'd0, pop_d0, pop_d1, valid_out, data_out, idle_out, active_out, error_out, cont_d0, cont_d1},
        32'd0);
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    apply_vec("rst_seq", 2, mk(1, 1, 6'h00, 1, 6'h00, 0, 2'b00, 0, 6'h00, 3'b000, 0, 0));
    apply_vec("rst_seq", 3, mk(0, 1, 6'h00, 1, 6'h00, 0, 2'b00, 0, 6'h00, 3'b100, 0, 0));

    // 35 consecutive D1 pops: counter must stick at 31.
    apply_vec("sat", 0, mk(0, 1, 6'h00, 0, 6'h15, 0, 2'b00, 0, 6'h00, 3'b010, 0, 0));
    for (int k = 1; k <= 35; k++) begin
      apply_vec("sat", k, mk(0, 1, 6'h00, 0, 6'h15, 0, 2'b01, 1, 6'h15, 3'b010, 0,
                             (k > 31) ? 5'd31 : 5'(k)));
    end
    apply_vec("sat", 36, mk(0, 1, 6'h00, 1, 6'h00, 0, 2'b00, 0, 6'h15, 3'b100, 0, 31));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
